ext_int_responder: RTL and testbench

Memory-mapped responder for the external interrupt line on the P7 system bridge. It synchronizes the raw `irq_in` driven by the environment, latches it into a pending flag, and drives `irq_out` to CP0 (HWInt). It accepts the CPU's acknowledge store at 0x7F20 and counts accepted interrupt events. It implements the device side of the interrupt/acknowledge handshake: source raises the line, CPU handler writes 0x7F20, source drops the line.

---
 rtl/ext_int_responder.sv | 176 +++++++++++++++++
 tb/tb_ext_int_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_responder.sv
// ext_int_responder
//   Memory-mapped responder for the external interrupt line. Synchronizes the
//   raw irq_in, latches events into a pending flag, drives irq_out to CP0 and
//   counts accepted events. The CPU handler acknowledges by storing to STATUS.
//
// Register map (word addresses, addr[1:0] ignored):
//   BASE+0  STATUS  {29'b0, hold, s2, pending}   any store = acknowledge
//   BASE+4  COUNT   32-bit event counter, byte-masked writable
//   BASE+8  CTRL    {30'b0, mode, en}            mode: 0 level, 1 edge
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   irq_in      - raw external interrupt, asynchronous to clk
//   addr        - bridge byte address
//   byteen      - store byte enables, nonzero = write this cycle
//   wdata       - store data
//   rdata       - combinational read data (0 when not hit)
//   irq_out     - registered interrupt request to CP0
//   hit         - combinational address match on any of the three registers
module ext_int_responder #(
    parameter logic [31:0] BASE = 32'h0000_7F20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_in,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq_out,
    output logic        hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [29:0] A_STAT = BASE[31:2];
    localparam logic [29:0] A_CNT  = A_STAT + 30'd1;
    localparam logic [29:0] A_CTRL = A_STAT + 30'd2;

    state_t      state_q, state_d;
    logic        s1_q, s2_q, s2_prev_q;
    logic [31:0] count_q, count_d;
    logic        mode_q, mode_d;
    logic        en_q, en_d;
    logic        irq_q, irq_d;

    logic sel_stat, sel_cnt, sel_ctrl;
    logic wr, ack, cnt_wr, ctrl_wr;
    logic ev, inc;

    // Byte offset bits are don't-care for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // ------------------------------------------------------------------
    // Address decode and write strobes
    // ------------------------------------------------------------------
    assign sel_stat = (addr[31:2] == A_STAT);
    assign sel_cnt  = (addr[31:2] == A_CNT);
    assign sel_ctrl = (addr[31:2] == A_CTRL);
    assign hit      = sel_stat | sel_cnt | sel_ctrl;

    assign wr      = |byteen;
    assign ack     = sel_stat & wr;
    assign cnt_wr  = sel_cnt & wr;
    // Only byte 0 of CTRL carries state.
    assign ctrl_wr = sel_ctrl & byteen[0];

    assign mode_d = ctrl_wr ? wdata[1] : mode_q;
    assign en_d   = ctrl_wr ? wdata[0] : en_q;

    // Event is evaluated with the CTRL value already registered, so a CTRL
    // store influences the event at the following edge.
    assign ev = en_q & (mode_q ? (s2_q & ~s2_prev_q) : s2_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s2_prev_q <= 1'b0;
            count_q   <= 32'd0;
            mode_q    <= 1'b0;
            en_q      <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= irq_in;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
            count_q   <= count_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            irq_q     <= irq_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d = PEND;
                    inc     = 1'b1;
                end
            end
            PEND: begin
                if (ack) begin
                    if (mode_q && ev) begin
                        // A fresh edge lands on the ack cycle: it becomes
                        // the new pending interrupt.
                        inc = 1'b1;
                    end else if (!mode_q && s2_q) begin
                        // Line still high in level mode; wait for it to
                        // drop so the synchronizer lag cannot re-trigger.
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!s2_q || mode_q || (mode_d != mode_q)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        irq_d = (state_d == PEND) & en_d;
    end

    // A COUNT store beats a same-cycle increment.
    always_comb begin
        count_d = count_q;
        if (cnt_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (byteen[b]) begin
                    count_d[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (inc) begin
            count_d = count_q + 32'd1;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel_stat) begin
            rdata = {29'd0, (state_q == HOLD), s2_q, (state_q == PEND)};
        end else if (sel_cnt) begin
            rdata = count_q;
        end else if (sel_ctrl) begin
            rdata = {30'd0, mode_q, en_q};
        end
    end

    assign irq_out = irq_q;

endmodule

// File: tb/tb_ext_int_responder.sv
module tb_ext_int_responder;

    localparam logic [31:0] S = 32'h0000_7F20;
    localparam logic [31:0] C = 32'h0000_7F24;
    localparam logic [31:0] R = 32'h0000_7F28;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_in;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq_out;
    logic        hit;

    int checks   = 0;
    int failures = 0;

    ext_int_responder #(.BASE(32'h0000_7F20)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_in (irq_in),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq_out(irq_out),
        .hit    (hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        irq;
        logic [31:0] a;
        logic [3:0]  be;
        logic        exp_irq;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr   = a;
        byteen = 4'h0;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic irq_chk(input string name, input logic exp);
        #1;
        chk(name, {31'd0, irq_out}, {31'd0, exp});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        cyc();
        byteen = 4'h0;
        wdata  = 32'd0;
    endtask

    task automatic pulse();
        irq_in = 1'b1;
        cyc();
        cyc();
        irq_in = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        // Basic handshake, one row per cycle; outputs are checked before the
        // edge, so reads show the state left by the previous row.
        //                irq a                be    irq hit rd
        tbl[0]  = '{1'b0, S,               4'h0, 1'b0, 1'b1, 32'd0};
        tbl[1]  = '{1'b1, R,               4'h0, 1'b0, 1'b1, 32'd1};
        tbl[2]  = '{1'b1, S,               4'h0, 1'b0, 1'b1, 32'd0};
        tbl[3]  = '{1'b1, S,               4'h0, 1'b0, 1'b1, 32'd2};
        tbl[4]  = '{1'b1, S,               4'hF, 1'b1, 1'b1, 32'd3};
        tbl[5]  = '{1'b0, S,               4'h0, 1'b0, 1'b1, 32'd6};
        tbl[6]  = '{1'b0, S,               4'h0, 1'b0, 1'b1, 32'd6};
        tbl[7]  = '{1'b0, S,               4'h0, 1'b0, 1'b1, 32'd4};
        tbl[8]  = '{1'b0, S,               4'h0, 1'b0, 1'b1, 32'd0};
        tbl[9]  = '{1'b0, C,               4'h0, 1'b0, 1'b1, 32'd1};
        tbl[10] = '{1'b0, R,               4'h0, 1'b0, 1'b1, 32'd1};
        tbl[11] = '{1'b0, 32'h0000_7F2C,   4'h0, 1'b0, 1'b0, 32'd0};
        tbl[12] = '{1'b0, 32'h0000_7F26,   4'h0, 1'b0, 1'b1, 32'd1};
        tbl[13] = '{1'b0, 32'h0001_7F20,   4'h0, 1'b0, 1'b0, 32'd0};

        reset  = 1'b1;
        irq_in = 1'b0;
        addr   = 32'd0;
        byteen = 4'h0;
        wdata  = 32'd0;
        @(negedge clk);
        cyc();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            irq_in = tbl[i].irq;
            addr   = tbl[i].a;
            byteen = tbl[i].be;
            wdata  = 32'd0;
            #1;
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq_out}, {31'd0, tbl[i].exp_irq});
            chk($sformatf("tbl%0d_hit", i), {31'd0, hit}, {31'd0, tbl[i].exp_hit});
            chk($sformatf("tbl%0d_rd", i), rdata, tbl[i].exp_rd);
            cyc();
        end
        byteen = 4'h0;

        // Edge mode: three pulses coalesce into one pending, counted once.
        wr(R, 32'd3, 4'h1);
        rd_chk("ctrl_edge", R, 32'd3);
        repeat (3) pulse();
        irq_chk("coal_irq", 1'b1);
        rd_chk("coal_stat", S, 32'd1);
        rd_chk("coal_cnt", C, 32'd2);
        wr(S, 32'd0, 4'hF);
        irq_chk("coal_ack_irq", 1'b0);
        rd_chk("coal_ack_stat", S, 32'd0);
        rd_chk("coal_ack_cnt", C, 32'd2);
        rd_chk("coal_ack_ctrl", R, 32'd3);

        // Ack coinciding with a synchronized rising edge keeps PEND.
        pulse();
        irq_chk("sim_pend_irq", 1'b1);
        irq_in = 1'b1;
        cyc();
        cyc();
        addr   = S;
        byteen = 4'hF;
        #1;
        chk("sim_pre_stat", rdata, 32'd3);
        cyc();
        byteen = 4'h0;
        irq_chk("sim_irq", 1'b1);
        rd_chk("sim_stat", S, 32'd3);
        rd_chk("sim_cnt", C, 32'd4);
        irq_in = 1'b0;
        repeat (3) cyc();
        wr(S, 32'd0, 4'hF);
        irq_chk("sim_clr_irq", 1'b0);

        // Mask / unmask with a pending interrupt, level mode.
        wr(R, 32'd1, 4'h1);
        irq_in = 1'b1;
        repeat (3) cyc();
        irq_chk("mask_pre_irq", 1'b1);
        irq_in = 1'b0;
        repeat (3) cyc();
        wr(R, 32'd0, 4'h1);
        irq_chk("mask_irq", 1'b0);
        rd_chk("mask_pend", S, 32'd1);
        pulse();
        rd_chk("mask_cnt", C, 32'd5);
        irq_chk("mask_hold_irq", 1'b0);
        wr(R, 32'd1, 4'h1);
        irq_chk("unmask_irq", 1'b1);
        wr(S, 32'd0, 4'hF);
        irq_chk("unmask_ack_irq", 1'b0);
        rd_chk("unmask_ack_stat", S, 32'd0);
        // Pulses while disabled from IDLE are neither counted nor latched.
        wr(R, 32'd0, 4'h1);
        pulse();
        rd_chk("dis_cnt", C, 32'd5);
        rd_chk("dis_stat", S, 32'd0);
        wr(R, 32'd1, 4'h1);
        repeat (3) cyc();
        irq_chk("dis_reen_irq", 1'b0);
        rd_chk("dis_reen_stat", S, 32'd0);

        // COUNT wrap.
        wr(C, 32'hFFFF_FFFF, 4'hF);
        rd_chk("wrap_load", C, 32'hFFFF_FFFF);
        irq_in = 1'b1;
        repeat (3) cyc();
        rd_chk("wrap_cnt", C, 32'd0);
        irq_chk("wrap_irq", 1'b1);
        irq_in = 1'b0;
        repeat (3) cyc();
        wr(S, 32'd0, 4'hF);
        // COUNT write on the same edge as an event: write wins.
        irq_in = 1'b1;
        cyc();
        cyc();
        wr(C, 32'hFFFF_FF05, 4'h1);
        rd_chk("prio_cnt", C, 32'd5);
        irq_chk("prio_irq", 1'b1);
        rd_chk("prio_stat", S, 32'd3);
        wr(C, 32'hDEAD_BEEF, 4'b0110);
        rd_chk("bytemask_cnt", C, 32'h00AD_BE05);

        // Reset while in HOLD with the line still high.
        wr(S, 32'd0, 4'hF);
        rd_chk("hold_stat", S, 32'd6);
        irq_chk("hold_irq", 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_stat", S, 32'd0);
        rd_chk("rst_cnt", C, 32'd0);
        rd_chk("rst_ctrl", R, 32'd1);
        cyc();
        cyc();
        rd_chk("rst_sync_stat", S, 32'd2);
        irq_chk("rst_sync_irq", 1'b0);
        cyc();
        rd_chk("rst_pend_stat", S, 32'd3);
        irq_chk("rst_pend_irq", 1'b1);
        rd_chk("rst_pend_cnt", C, 32'd1);

        // Switching to edge mode while in HOLD returns to IDLE.
        wr(S, 32'd0, 4'hF);
        rd_chk("mchg_hold", S, 32'd6);
        wr(R, 32'd3, 4'h1);
        rd_chk("mchg_idle", S, 32'd2);
        irq_chk("mchg_irq", 1'b0);
        cyc();
        rd_chk("mchg_stay", S, 32'd2);
        rd_chk("mchg_cnt", C, 32'd1);
        irq_in = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
